// File: rtl/combo_pkg.sv
// Shared constants for the combination-lock code writer: state encoding,
// default geometry and Status LED bit positions.
package combo_pkg;

  localparam int unsigned DefNumDigits = 4;
  localparam int unsigned DefDigitW    = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEnter   = 3'd1,
    StConfirm = 3'd2,
    StCommit  = 3'd3,
    StError   = 3'd4
  } state_e;

  localparam int unsigned StatusIdle    = 0;
  localparam int unsigned StatusEnter   = 1;
  localparam int unsigned StatusConfirm = 2;
  localparam int unsigned StatusError   = 3;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge press detector for an already-synchronized button level.
// History resets high so a button held through reset never reads as a press.
module key_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_press
);

  logic r_hist;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= i_key;
    end
  end

  assign o_press = i_key & ~r_hist;

endmodule

// File: rtl/combination_programmer.sv
// Enrolls a new lock combination (entered twice, committed on exact match)
// and drives the stored code compared by the lock FSM.
module combination_programmer
  import combo_pkg::*;
#(
  parameter int unsigned                      NUM_DIGITS   = DefNumDigits,
  parameter int unsigned                      DIGIT_W      = DefDigitW,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]    DEFAULT_CODE = 16'h1234
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Unlocked,
  input  logic                          Key0,
  input  logic                          Key1,
  input  logic [DIGIT_W-1:0]            Switches,
  output logic [NUM_DIGITS*DIGIT_W-1:0] Code,
  output logic                          CodeWritten,
  output logic [3:0]                    Status,
  output logic [2:0]                    state
);

  localparam int unsigned    CntW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_DIGITS - 1);

  logic w_key0_press;
  logic w_key1_press;

  key_edge_detect u_key0_edge (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_key   (Key0),
    .o_press (w_key0_press)
  );

  key_edge_detect u_key1_edge (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_key   (Key1),
    .o_press (w_key1_press)
  );

  state_e                                r_state;
  state_e                                w_state_next;
  logic [CntW-1:0]                       r_cnt;
  logic [CntW-1:0]                       w_cnt_next;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    r_shadow;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    w_shadow_next;
  logic                                  r_mismatch;
  logic                                  w_mismatch_next;
  logic [NUM_DIGITS*DIGIT_W-1:0]         r_code;
  logic                                  r_code_written;
  logic [CntW-1:0]                       w_field;
  logic                                  w_digit_bad;
  logic                                  w_last;

  // Digit 0 is entered first and lives in the most significant field.
  assign w_field     = LastIdx - r_cnt;
  assign w_digit_bad = (Switches != r_shadow[w_field]);
  assign w_last      = (r_cnt == LastIdx);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_shadow   <= w_shadow_next;
      r_mismatch <= w_mismatch_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_shadow_next   = r_shadow;
    w_mismatch_next = r_mismatch;
    unique case (r_state)
      StIdle: begin
        if (w_key1_press && Unlocked) begin
          w_state_next    = StEnter;
          w_cnt_next      = '0;
          w_shadow_next   = '0;
          w_mismatch_next = 1'b0;
        end
      end
      StEnter: begin
        // Losing Unlocked or a Key1 press discards the partial entry; Key1 beats Key0.
        if (!Unlocked || w_key1_press) begin
          w_state_next = StIdle;
        end else if (w_key0_press) begin
          w_shadow_next[w_field] = Switches;
          if (w_last) begin
            w_state_next = StConfirm;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      StConfirm: begin
        if (!Unlocked || w_key1_press) begin
          w_state_next = StIdle;
        end else if (w_key0_press) begin
          w_mismatch_next = r_mismatch | w_digit_bad;
          if (w_last) begin
            w_state_next = (r_mismatch || w_digit_bad) ? StError : StCommit;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      StCommit: begin
        w_state_next = StIdle;
      end
      StError: begin
        if (w_key1_press) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_code         <= DEFAULT_CODE;
      r_code_written <= 1'b0;
    end else begin
      r_code_written <= (r_state == StCommit);
      if (r_state == StCommit) begin
        r_code <= r_shadow;
      end
    end
  end

  always_comb begin
    Status                = '0;
    Status[StatusIdle]    = (r_state == StIdle);
    Status[StatusEnter]   = (r_state == StEnter);
    Status[StatusConfirm] = (r_state == StConfirm);
    Status[StatusError]   = (r_state == StError);
  end

  assign state       = r_state;
  assign Code        = r_code;
  assign CodeWritten = r_code_written;

endmodule

// File: tb/tb_combination_programmer.sv
// Directed bench for combination_programmer: a digit-list model predicts every
// output each cycle, and literal expectations pin key points of the scenario.
module tb_combination_programmer;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Unlocked = 1'b0;
  logic        Key0 = 1'b0;
  logic        Key1 = 1'b0;
  logic [3:0]  Switches = 4'h0;
  logic [15:0] Code;
  logic        CodeWritten;
  logic [3:0]  Status;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int n_cw_seen = 0;

  always #5 Clk = ~Clk;

  combination_programmer #(
    .NUM_DIGITS   (4),
    .DIGIT_W      (4),
    .DEFAULT_CODE (16'h1234)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Unlocked    (Unlocked),
    .Key0        (Key0),
    .Key1        (Key1),
    .Switches    (Switches),
    .Code        (Code),
    .CodeWritten (CodeWritten),
    .Status      (Status),
    .state       (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 entering, 2 confirming, 3 committing, 4 error.
  int          m_mode = 0;
  logic [15:0] m_code = 16'h1234;
  bit          m_wr = 0;
  int          m_cnt = 0;
  bit          m_bad = 0;
  int          m_digits[N];
  bit          m_prev0 = 1, m_prev1 = 1;
  bit          m_valid = 0;

  function automatic logic [3:0] exp_status(input int mode);
    case (mode)
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      4:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Inputs change 1 time unit after posedge, so at negedge they equal what the
  // next posedge samples: compare the last edge's result, then step the model.
  initial begin
    bit p0, p1;
    forever begin
      @(negedge Clk);
      if (m_valid) begin
        check("state", 32'(state), 32'(m_mode));
        check("Status", 32'(Status), 32'(exp_status(m_mode)));
        check("Code", 32'(Code), 32'(m_code));
        check("CodeWritten", 32'(CodeWritten), 32'(m_wr));
        if (CodeWritten === 1'b1) n_cw_seen++;
      end
      if (Reset) begin
        m_mode = 0; m_code = 16'h1234; m_wr = 0; m_cnt = 0; m_bad = 0;
        foreach (m_digits[i]) m_digits[i] = 0;
        m_prev0 = 1; m_prev1 = 1; m_valid = 1;
      end else begin
        p0 = Key0 && !m_prev0;
        p1 = Key1 && !m_prev1;
        m_prev0 = Key0;
        m_prev1 = Key1;
        m_wr = 0;
        case (m_mode)
          0: if (p1 && Unlocked) begin
               m_mode = 1; m_cnt = 0; m_bad = 0;
               foreach (m_digits[i]) m_digits[i] = 0;
             end
          1: if (p1 || !Unlocked) m_mode = 0;
             else if (p0) begin
               m_digits[m_cnt] = int'(Switches);
               if (m_cnt == N - 1) begin m_mode = 2; m_cnt = 0; end
               else m_cnt++;
             end
          2: if (p1 || !Unlocked) m_mode = 0;
             else if (p0) begin
               if (int'(Switches) != m_digits[m_cnt]) m_bad = 1;
               if (m_cnt == N - 1) begin m_mode = m_bad ? 4 : 3; m_cnt = 0; end
               else m_cnt++;
             end
          3: begin
               m_code = 16'h0;
               for (int i = 0; i < N; i++) m_code = (m_code << 4) | 16'(m_digits[i]);
               m_wr = 1;
               m_mode = 0;
             end
          4: if (p1) m_mode = 0;
          default: m_mode = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press0(input logic [3:0] d);
    Switches = d; Key0 = 1'b1; tick();
    Key0 = 1'b0; tick();
  endtask

  task automatic press1();
    Key1 = 1'b1; tick();
    Key1 = 1'b0; tick();
  endtask

  task automatic digits4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    press0(a); press0(b); press0(c); press0(d);
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    repeat (cycles) tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    // 1: reset state
    Reset = 1'b1;
    tick(); tick();
    check("reset Code", 32'(Code), 32'h1234);
    check("reset state", 32'(state), 32'd0);
    check("reset Status", 32'(Status), 32'b0001);
    check("reset CodeWritten", 32'(CodeWritten), 32'd0);
    Reset = 1'b0;
    tick();

    // 2: enroll 5678
    Unlocked = 1'b1;
    press1();
    check("t2 enter state", 32'(state), 32'd1);
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    check("t2 confirm state", 32'(state), 32'd2);
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    check("t2 Code", 32'(Code), 32'h5678);
    check("t2 model code", 32'(m_code), 32'h5678);
    check("t2 CodeWritten pulse", 32'(CodeWritten), 32'd1);
    check("t2 back to idle", 32'(state), 32'd0);
    tick();
    check("t2 pulse ends", 32'(CodeWritten), 32'd0);

    // 3: confirm mismatch, from a fresh reset
    do_reset(2);
    press1();
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    digits4(4'd5, 4'd6, 4'd7, 4'd9);
    check("t3 error state", 32'(state), 32'd4);
    check("t3 error Status", 32'(Status), 32'b1000);
    check("t3 Code kept", 32'(Code), 32'h1234);
    Unlocked = 1'b0;
    repeat (3) tick();
    check("t3 error ignores Unlocked", 32'(state), 32'd4);
    press1();
    check("t3 clear error", 32'(state), 32'd0);
    Unlocked = 1'b1;
    press1();
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    digits4(4'd5, 4'd0, 4'd7, 4'd8);
    check("t3 sticky mismatch", 32'(state), 32'd4);
    press1();

    // 4: locked start ignored; unlock lost mid-entry
    Unlocked = 1'b0;
    press1();
    check("t4 locked start", 32'(state), 32'd0);
    Unlocked = 1'b1;
    press1();
    press0(4'd2); press0(4'd3);
    Unlocked = 1'b0;
    tick();
    check("t4 unlock lost", 32'(state), 32'd0);
    check("t4 Code kept", 32'(Code), 32'h1234);
    Unlocked = 1'b1;
    tick();

    // 5: held Key0 counts once; simultaneous keys abort
    press1();
    Switches = 4'd9; Key0 = 1'b1;
    repeat (10) tick();
    Key0 = 1'b0;
    tick();
    press0(4'd1); press0(4'd2);
    check("t5 still entering", 32'(state), 32'd1);
    press0(4'd3);
    check("t5 confirm after 4", 32'(state), 32'd2);
    digits4(4'd9, 4'd1, 4'd2, 4'd3);
    check("t5 Code", 32'(Code), 32'h9123);
    check("t5 CodeWritten", 32'(CodeWritten), 32'd1);
    press1();
    press0(4'd4);
    Switches = 4'd7; Key0 = 1'b1; Key1 = 1'b1;
    tick();
    check("t5 both keys abort", 32'(state), 32'd0);
    Key0 = 1'b0; Key1 = 1'b0;
    tick();

    // 6: Key1 held through reset; reset mid-confirm
    Key1 = 1'b1;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    repeat (3) tick();
    check("t6 held key no press", 32'(state), 32'd0);
    Key1 = 1'b0;
    tick();
    press1();
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    check("t6 Code committed", 32'(Code), 32'h5678);
    press1();
    digits4(4'd5, 4'd6, 4'd7, 4'd8);
    press0(4'd5); press0(4'd6);
    check("t6 mid confirm", 32'(state), 32'd2);
    Reset = 1'b1;
    tick();
    check("t6 reset Code", 32'(Code), 32'h1234);
    check("t6 reset state", 32'(state), 32'd0);
    check("t6 reset Status", 32'(Status), 32'b0001);
    Reset = 1'b0;
    tick(); tick();
    check("CodeWritten pulse count", 32'(n_cw_seen), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
